// File: rtl/wm_block_gather_pkg.sv
// Shared constants and row-phase encoding for the 2x2 block gatherer.
package wm_pkg;

    localparam int PIX_W_DEF      = 8;
    localparam int IMG_WIDTH_DEF  = 8;
    localparam int IMG_HEIGHT_DEF = 8;

    typedef enum logic {
        ROW_TOP = 1'b0,
        ROW_BOT = 1'b1
    } row_state_t;

endpackage

// File: rtl/wm_block_gather_if.sv
// Pixel-in / block-out handshake bundle between the gatherer and its neighbours.
interface wm_block_gather_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] Data1;
    logic [PIX_W-1:0] Data2;
    logic [PIX_W-1:0] Data3;
    logic [PIX_W-1:0] Data4;
    logic             blk_valid;
    logic             blk_ready;
    logic             frame_done;

    modport master (
        output pix_in, pix_valid, blk_ready,
        input  pix_ready, Data1, Data2, Data3, Data4, blk_valid, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, blk_ready,
        output pix_ready, Data1, Data2, Data3, Data4, blk_valid, frame_done
    );
endinterface

// File: rtl/wm_block_gather_line_buf.sv
// One-line pixel store: a single write port and two asynchronous read ports
// so both top-row pixels of a block are available on the bottom-right accept.
module wm_line_buf #(
    parameter int PIX_W  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [PIX_W-1:0]  rdata_a,
    output logic [PIX_W-1:0]  rdata_b
);
    logic [PIX_W-1:0] mem_q [DEPTH];

    // Contents need no reset: every entry is rewritten on a top row before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/wm_block_gather.sv
// Regroups a raster pixel stream into non-overlapping 2x2 blocks using one
// line buffer; the top row is buffered, the bottom row completes each block.
module wm_block_gather
    import wm_pkg::*;
#(
    parameter int PIX_W      = PIX_W_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    wm_block_gather_if.slave bus
);
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    row_state_t       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PIX_W-1:0] hold_q, hold_d;
    logic [PIX_W-1:0] data_q [4];
    logic [PIX_W-1:0] data_d [4];
    logic             blk_valid_q, blk_valid_d;
    logic             frame_done_q, frame_done_d;

    logic             pix_ready, accept, line_end, frame_end, load_blk, lb_we;
    logic [COL_W-1:0] rd_addr_left;
    logic [PIX_W-1:0] rd_left, rd_right;

    // Input stalls only while a finished block is held and not being taken.
    assign pix_ready    = !(blk_valid_q && !bus.blk_ready);
    assign accept       = bus.pix_valid && pix_ready;
    assign line_end     = (col_q == COL_LAST);
    assign frame_end    = line_end && (row_q == ROW_LAST);
    assign load_blk     = accept && (state_q == ROW_BOT) && col_q[0];
    assign lb_we        = accept && (state_q == ROW_TOP);
    assign rd_addr_left = col_q & ~COL_W'(1);

    wm_line_buf #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_WIDTH),
        .ADDR_W(COL_W)
    ) u_line_buf (
        .clk    (clk),
        .we     (lb_we),
        .waddr  (col_q),
        .wdata  (bus.pix_in),
        .raddr_a(rd_addr_left),
        .raddr_b(col_q),
        .rdata_a(rd_left),
        .rdata_b(rd_right)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ROW_TOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ROW_TOP: if (accept && line_end) state_d = ROW_BOT;
            ROW_BOT: if (accept && line_end) state_d = ROW_TOP;
            default: state_d = ROW_TOP;
        endcase
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        blk_valid_d  = blk_valid_q;
        frame_done_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
        end

        if (accept) begin
            if (line_end) begin
                col_d = '0;
                row_d = frame_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if ((state_q == ROW_BOT) && !col_q[0]) begin
                hold_d = bus.pix_in;
            end
        end

        if (blk_valid_q && bus.blk_ready) begin
            blk_valid_d = 1'b0;
        end

        // A new block overrides a same-cycle completion, keeping valid high.
        if (load_blk) begin
            data_d[0]    = rd_left;
            data_d[1]    = rd_right;
            data_d[2]    = hold_q;
            data_d[3]    = bus.pix_in;
            blk_valid_d  = 1'b1;
            frame_done_d = frame_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            blk_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            blk_valid_q  <= blk_valid_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.Data1      = data_q[0];
    assign bus.Data2      = data_q[1];
    assign bus.Data3      = data_q[2];
    assign bus.Data4      = data_q[3];
    assign bus.blk_valid  = blk_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_wm_block_gather.sv
// Self-checking bench: a 4x2 and an 8x8 gatherer driven with random/patterned
// streams, with blocks checked against a frame-geometry reference model.
module tb_wm_block_gather;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wm_block_gather_if #(.PIX_W(8)) if_s ();
    wm_block_gather_if #(.PIX_W(8)) if_l ();

    wm_block_gather #(.PIX_W(8), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s)
    );
    wm_block_gather #(.PIX_W(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(if_l)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  px [0:255];
    logic [31:0] obs_s [$];
    logic [31:0] obs_l [$];
    logic [31:0] exp_q [$];
    int          fd_s = 0, fd_l = 0, fd_bad_s = 0, fd_bad_l = 0;
    logic [31:0] fd_blk_s = '0, fd_blk_l = '0;

    // Observed transfers and frame_done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && if_s.blk_valid && if_s.blk_ready)
            obs_s.push_back({if_s.Data1, if_s.Data2, if_s.Data3, if_s.Data4});
        if (rst_n && if_l.blk_valid && if_l.blk_ready)
            obs_l.push_back({if_l.Data1, if_l.Data2, if_l.Data3, if_l.Data4});
        if (if_s.frame_done) begin
            fd_s     <= fd_s + 1;
            fd_blk_s <= {if_s.Data1, if_s.Data2, if_s.Data3, if_s.Data4};
            if (!if_s.blk_valid) fd_bad_s <= fd_bad_s + 1;
        end
        if (if_l.frame_done) begin
            fd_l     <= fd_l + 1;
            fd_blk_l <= {if_l.Data1, if_l.Data2, if_l.Data3, if_l.Data4};
            if (!if_l.blk_valid) fd_bad_l <= fd_bad_l + 1;
        end
    end

    // Reference: block (br,bc) of frame f takes rows 2br/2br+1, cols 2bc/2bc+1.
    function automatic void build_exp(input int w, input int h, input int nf);
        exp_q.delete();
        for (int f = 0; f < nf; f++)
            for (int br = 0; br < h / 2; br++)
                for (int bc = 0; bc < w / 2; bc++) begin
                    int t, b;
                    t = f * w * h + 2 * br * w + 2 * bc;
                    b = t + w;
                    exp_q.push_back({px[t], px[t + 1], px[b], px[b + 1]});
                end
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] p, input logic r);
        if (sel) begin
            if_l.pix_valid = v; if_l.pix_in = p; if_l.blk_ready = r;
        end else begin
            if_s.pix_valid = v; if_s.pix_in = p; if_s.blk_ready = r;
        end
    endtask

    function automatic logic get_pready(input bit sel);
        return sel ? if_l.pix_ready : if_s.pix_ready;
    endfunction

    function automatic logic get_bvalid(input bit sel);
        return sel ? if_l.blk_valid : if_s.blk_valid;
    endfunction

    // vmode: 0 always valid, 1 toggling, 2 random; rmode: 0 always ready, 1 random.
    task automatic run_frame(input bit sel, input int first, input int n,
                             input int vmode, input int rmode, input bit drain);
        int   idx, cyc, k;
        logic v, r, taken;
        idx = first; cyc = 0; taken = 1'b0;
        while (1) begin
            @(posedge clk);
            if (taken) idx++;
            if (idx >= n) break;
            cyc++;
            if (cyc > 5000) begin
                n_checks++; n_fail++;
                $display("FAIL run_frame_timeout: accepted %0d required %0d", idx, n);
                break;
            end
            #1;
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? cyc[0] : ($urandom_range(3, 0) != 0);
            r = (rmode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            drive(sel, v, px[idx], r);
            @(negedge clk);
            taken = v && get_pready(sel);
        end
        #1 drive(sel, 1'b0, 8'h00, 1'b1);
        if (drain) begin
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!get_bvalid(sel)) break;
                @(posedge clk);
            end
            n_checks++;
            if (k == 20) begin
                n_fail++;
                $display("FAIL drain_timeout: blk_valid still 1 after %0d cycles, required 0", k);
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            logic [31:0] d; logic bv, fd, pr;
            d  = s ? {if_l.Data1, if_l.Data2, if_l.Data3, if_l.Data4}
                   : {if_s.Data1, if_s.Data2, if_s.Data3, if_s.Data4};
            bv = s ? if_l.blk_valid : if_s.blk_valid;
            fd = s ? if_l.frame_done : if_s.frame_done;
            pr = s ? if_l.pix_ready : if_s.pix_ready;
            n_checks++; if (d !== 32'h0)  begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 0", s, d); end
            n_checks++; if (bv !== 1'b0)  begin n_fail++; $display("FAIL reset_blk_valid[%0d]: got %b want 0", s, bv); end
            n_checks++; if (fd !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_done[%0d]: got %b want 0", s, fd); end
            n_checks++; if (pr !== 1'b1)  begin n_fail++; $display("FAIL reset_pix_ready[%0d]: got %b want 1", s, pr); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int fd0;
        for (int i = 0; i < 8; i++) px[i] = 8'(i);
        obs_s.delete(); fd0 = fd_s;
        run_frame(1'b0, 0, 8, 0, 0, 1'b1);
        build_exp(4, 2, 1);
        n_checks++;
        if (obs_s.size() !== 2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", obs_s.size()); end
        for (int i = 0; i < obs_s.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_s[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_blk%0d: got %h want %h", i, obs_s[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_s.size() > 1 && obs_s[1] !== 32'h02030607) begin n_fail++; $display("FAIL basic_blk1_const: got %h want 02030607", obs_s[1]); end
        n_checks++;
        if (fd_s - fd0 !== 1) begin n_fail++; $display("FAIL basic_frame_done: got %0d pulses want 1", fd_s - fd0); end
        n_checks++;
        if (fd_blk_s !== 32'h02030607) begin n_fail++; $display("FAIL basic_fd_block: got %h want 02030607", fd_blk_s); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) px[i] = 8'(8'h40 + i);
        obs_s.delete();
        run_frame(1'b0, 0, 6, 0, 0, 1'b0);
        drive(1'b0, 1'b1, px[6], 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (if_s.pix_ready !== 1'b0) begin n_fail++; $display("FAIL stall_pix_ready c%0d: got %b want 0", c, if_s.pix_ready); end
            n_checks++;
            if (if_s.blk_valid !== 1'b1) begin n_fail++; $display("FAIL stall_blk_valid c%0d: got %b want 1", c, if_s.blk_valid); end
            n_checks++;
            if ({if_s.Data1, if_s.Data2, if_s.Data3, if_s.Data4} !== 32'h40414445) begin
                n_fail++; $display("FAIL stall_data c%0d: got %h want 40414445", c, {if_s.Data1, if_s.Data2, if_s.Data3, if_s.Data4});
            end
            @(posedge clk);
        end
        run_frame(1'b0, 6, 8, 0, 0, 1'b1);
        build_exp(4, 2, 1);
        n_checks++;
        if (obs_s.size() !== 2) begin n_fail++; $display("FAIL stall_count: got %0d want 2", obs_s.size()); end
        for (int i = 0; i < obs_s.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_s[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_blk%0d: got %h want %h", i, obs_s[i], exp_q[i]); end
        end
    endtask

    task automatic test_toggle_8x8();
        int fd0;
        for (int i = 0; i < 64; i++) px[i] = 8'(i);
        obs_l.delete(); fd0 = fd_l;
        run_frame(1'b1, 0, 64, 1, 0, 1'b1);
        build_exp(8, 8, 1);
        n_checks++;
        if (obs_l.size() !== 16) begin n_fail++; $display("FAIL toggle_count: got %0d want 16", obs_l.size()); end
        for (int i = 0; i < obs_l.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_l[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_blk%0d: got %h want %h", i, obs_l[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_l.size() > 5 && obs_l[5] !== 32'h12131A1B) begin n_fail++; $display("FAIL toggle_blk5_const: got %h want 12131a1b", obs_l[5]); end
        n_checks++;
        if (fd_l - fd0 !== 1 || fd_bad_l !== 0) begin n_fail++; $display("FAIL toggle_frame_done: got %0d pulses (%0d bad) want 1", fd_l - fd0, fd_bad_l); end
        n_checks++;
        if (fd_blk_l !== 32'h36373E3F) begin n_fail++; $display("FAIL toggle_fd_block: got %h want 36373e3f", fd_blk_l); end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) px[i] = 8'($urandom_range(255, 0));
        run_frame(1'b0, 0, 5, 0, 0, 1'b0);
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({if_s.Data1, if_s.Data2, if_s.Data3, if_s.Data4, 6'b0, if_s.blk_valid, if_s.frame_done} !== 40'h0) begin
            n_fail++; $display("FAIL midreset_outputs: data %h valid %b fd %b want all 0",
                {if_s.Data1, if_s.Data2, if_s.Data3, if_s.Data4}, if_s.blk_valid, if_s.frame_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) px[i] = 8'(8'h10 + i);
        obs_s.delete();
        run_frame(1'b0, 0, 8, 0, 0, 1'b1);
        n_checks++;
        if (obs_s.size() !== 2) begin n_fail++; $display("FAIL midreset_count: got %0d want 2", obs_s.size()); end
        n_checks++;
        if (obs_s.size() > 0 && obs_s[0] !== 32'h10111415) begin n_fail++; $display("FAIL midreset_blk0: got %h want 10111415", obs_s[0]); end
        n_checks++;
        if (obs_s.size() > 1 && obs_s[1] !== 32'h12131617) begin n_fail++; $display("FAIL midreset_blk1: got %h want 12131617", obs_s[1]); end
    endtask

    task automatic test_back_to_back();
        int fd0;
        for (int i = 0; i < 16; i++) px[i] = 8'($urandom_range(255, 0));
        obs_s.delete(); fd0 = fd_s;
        run_frame(1'b0, 0, 16, 0, 0, 1'b1);
        build_exp(4, 2, 2);
        n_checks++;
        if (obs_s.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", obs_s.size()); end
        for (int i = 0; i < obs_s.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_s[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_blk%0d: got %h want %h", i, obs_s[i], exp_q[i]); end
        end
        n_checks++;
        if (fd_s - fd0 !== 2 || fd_bad_s !== 0) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses (%0d bad) want 2", fd_s - fd0, fd_bad_s); end
    endtask

    task automatic test_random_flow(input int vmode, input int rmode);
        int fd0;
        for (int i = 0; i < 128; i++) px[i] = 8'($urandom_range(255, 0));
        obs_l.delete(); fd0 = fd_l;
        run_frame(1'b1, 0, 128, vmode, rmode, 1'b1);
        build_exp(8, 8, 2);
        n_checks++;
        if (obs_l.size() !== 32) begin n_fail++; $display("FAIL flow%0d%0d_count: got %0d want 32", vmode, rmode, obs_l.size()); end
        for (int i = 0; i < obs_l.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_l[i] !== exp_q[i]) begin n_fail++; $display("FAIL flow%0d%0d_blk%0d: got %h want %h", vmode, rmode, i, obs_l[i], exp_q[i]); end
        end
        n_checks++;
        if (fd_l - fd0 !== 2 || fd_bad_l !== 0) begin n_fail++; $display("FAIL flow%0d%0d_frame_done: got %0d pulses (%0d bad) want 2", vmode, rmode, fd_l - fd0, fd_bad_l); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle_8x8();
        test_reset_midframe();
        test_back_to_back();
        test_random_flow(0, 0);
        test_random_flow(2, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
